mips_mem_responder: RTL

//   Memory-side responder for the multi-cycle MIPS core's instruction and data ports.
//   - Serves instruction fetches on instr_addr and data loads/stores on data_addr/data_rd_wr.
//   - A streaming loader fills the program image before the core is released.
//   - Reports sticky range/alignment errors for bench checking.

---
 rtl/mips_mem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_mem_responder
//
// Memory-side responder for the multi-cycle MIPS core. A streaming loader
// fills the program image while the core is held; once the loader flags its
// last word the core is released and served instruction fetches and data
// loads/stores from the same word array. Range and alignment problems are
// recorded in sticky error flags, together with the first offending address.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous, active-low reset
//   instr_addr  core fetch byte address
//   instr_in    fetched word, registered (1-cycle latency)
//   data_addr   core load/store byte address
//   data_rd_wr  1 = read, 0 = write data_out to data_addr
//   data_out    core store data
//   data_in     load data, registered (1-cycle latency)
//   ld_valid    loader word valid
//   ld_ready    loader handshake ready (high only while loading)
//   ld_data     loader word
//   ld_last     marks the final loader word
//   cpu_hold    1 while the image is not yet loaded
//   err_range   sticky: access or load outside the memory window
//   err_align   sticky: core address with [1:0] != 0
//   err_addr    first offending address of either error type
//   wr_count    number of committed core write cycles
// ---------------------------------------------------------------------------
module mips_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h80020000,
  parameter int          DEPTH_LOG2 = 18,
  parameter logic [31:0] OOR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic        data_rd_wr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_hold,
  output logic        err_range,
  output logic        err_align,
  output logic [31:0] err_addr,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t                state;
  // One extra bit so the pointer can reach DEPTH and flag loader overflow.
  logic [DEPTH_LOG2:0]   ptr;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           instr_off;
  logic [31:0]           data_off;
  logic                  instr_in_range;
  logic                  data_in_range;
  logic [DEPTH_LOG2-1:0] instr_idx;
  logic [DEPTH_LOG2-1:0] data_idx;
  logic                  instr_misaligned;
  logic                  data_misaligned;
  logic                  instr_err;
  logic                  data_err;
  logic                  ptr_full;
  logic                  any_err;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  // Offsets use modulo-2^32 subtraction, so addresses below the base wrap to
  // huge offsets and naturally fall out of range.
  assign instr_off        = instr_addr - BASE_ADDR;
  assign data_off         = data_addr - BASE_ADDR;
  assign instr_in_range   = (instr_off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign data_in_range    = (data_off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign instr_idx        = instr_off[DEPTH_LOG2+1:2];
  assign data_idx         = data_off[DEPTH_LOG2+1:2];
  assign instr_misaligned = instr_addr[1:0] != 2'b00;
  assign data_misaligned  = data_addr[1:0] != 2'b00;
  assign instr_err        = !instr_in_range || instr_misaligned;
  assign data_err         = !data_in_range || data_misaligned;
  assign ptr_full         = ptr[DEPTH_LOG2];
  assign any_err          = err_range || err_align;

  // Single memory write port shared by the loader (LOAD) and the core's store
  // path (RUN); the two never overlap because they belong to different states.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (reset) begin
      if (state == LOAD) begin
        if (ld_valid && !ptr_full) begin
          mem_we    = 1'b1;
          mem_waddr = ptr[DEPTH_LOG2-1:0];
          mem_wdata = ld_data;
        end
      end else if (!data_rd_wr && data_in_range) begin
        mem_we    = 1'b1;
        mem_waddr = data_idx;
        mem_wdata = data_out;
      end
    end
  end

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered outputs. Reads sample the array before the
  // write above lands, which gives read-first behaviour on a same-word clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      ptr       <= '0;
      instr_in  <= '0;
      data_in   <= '0;
      ld_ready  <= 1'b1;
      cpu_hold  <= 1'b1;
      err_range <= 1'b0;
      err_align <= 1'b0;
      err_addr  <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_valid) begin
            if (ptr_full) begin
              // Overflow word is dropped; the pointer stays saturated.
              err_range <= 1'b1;
              if (!any_err) begin
                err_addr <= BASE_ADDR + 32'({ptr, 2'b00});
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
            if (ld_last) begin
              state    <= RUN;
              ld_ready <= 1'b0;
              cpu_hold <= 1'b0;
            end
          end
        end
        RUN: begin
          instr_in <= instr_in_range ? mem[instr_idx] : OOR_DATA;
          data_in  <= data_in_range  ? mem[data_idx]  : OOR_DATA;
          if (!instr_in_range || !data_in_range) begin
            err_range <= 1'b1;
          end
          if (instr_misaligned || data_misaligned) begin
            err_align <= 1'b1;
          end
          // Only the very first error is recorded; the data port wins a tie.
          if (!any_err && (data_err || instr_err)) begin
            err_addr <= data_err ? data_addr : instr_addr;
          end
          if (!data_rd_wr && data_in_range) begin
            wr_count <= wr_count + 32'd1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
